// File: rtl/wc_tile_loader_pkg.sv
// Purpose: shared constants and types for the WC_6_4 input tile loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DW/T/TILE_N constants, address widths, sample_t, row_t and the write-side state enum.
package wc_pkg;

    localparam int DW     = 10;        // sample width in bits
    localparam int T      = 6;         // tile edge in samples
    localparam int TILE_N = T * T;     // samples per tile
    localparam int AW     = 6;         // bank element address width (0..TILE_N-1)
    localparam int RW     = 3;         // row/column index width (0..T-1)

    typedef logic [DW-1:0]       sample_t;
    typedef sample_t [T-1:0]     row_t;   // element c at bits [c*DW +: DW]

    // Write side either fills the current bank or waits for it to be freed.
    typedef enum logic {
        WR_FILL  = 1'b0,
        WR_STALL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/wc_tile_loader_if.sv
// Purpose: sample-in / row-out handshake bundle of the tile loader.
// Latency: n/a (wiring only).
// Backpressure: din_vld/din_rdy on the sample side, row_vld/row_rdy on the row side.
// Modports: master = pad-ring/transform side (drives din, din_vld, row_rdy); slave = the loader.
interface wc_tile_loader_if;
    import wc_pkg::*;

    sample_t         din;
    logic            din_vld;
    logic            din_rdy;
    row_t            row_data;
    logic [RW-1:0]   row_idx;
    logic            row_vld;
    logic            row_rdy;
    logic            tile_last;

    modport master (
        output din, din_vld, row_rdy,
        input  din_rdy, row_data, row_idx, row_vld, tile_last
    );

    modport slave (
        input  din, din_vld, row_rdy,
        output din_rdy, row_data, row_idx, row_vld, tile_last
    );

endinterface

// File: rtl/wc_tile_loader_bank.sv
// Purpose: one T*T register bank, single write port, combinational row (or column) read port.
// Latency: write lands at the clock edge; read is combinational from ridx.
// Backpressure: none; the caller decides when to write.
// Ports: clk; we/waddr/wdata write port; ridx selects the read slice; rdata is that slice.
// Config: WC_LOADER_TRANSPOSE_EN makes ridx select a column instead of a row.
module wc_tile_bank
    import wc_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  sample_t         wdata,
    input  logic [RW-1:0]   ridx,
    output row_t            rdata
);

    // Contents are deliberately not reset: the full flags qualify them.
    sample_t mem [TILE_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar c = 0; c < T; c++) begin : g_rd
`ifdef WC_LOADER_TRANSPOSE_EN
        // Column ridx: element c comes from tile position (c, ridx).
        assign rdata[c] = mem[AW'(c * T) + AW'(ridx)];
`else
        // Row ridx: element c comes from tile position (ridx, c).
        assign rdata[c] = mem[AW'(ridx) * AW'(T) + AW'(c)];
`endif
    end

endmodule

// File: rtl/wc_tile_loader.sv
// Purpose: assemble 6x6 input tiles row-major into ping-pong banks and stream them out one row per cycle.
// Latency: last sample accepted at edge N -> row 0 valid in cycle N+1; 6 cycles minimum drain per tile.
// Backpressure: din_rdy drops only while both banks hold undrained tiles; rows hold stable while row_rdy=0.
// Ports: clk, rst (synchronous, active-low), io (slave side of wc_tile_loader_if).
// Config: WC_LOADER_TRANSPOSE_EN presents columns instead of rows (handled inside wc_tile_bank).
module wc_tile_loader
    import wc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    wc_tile_loader_if.slave     io
);

    logic [AW-1:0]  wp, wp_nxt;       // write element pointer
    logic [RW-1:0]  rr, rr_nxt;       // read row pointer
    logic           wb, wb_nxt;       // write bank
    logic           rb, rb_nxt;       // read bank
    logic [1:0]     full, full_nxt;   // per-bank tile-complete flag

    wr_state_e      wr_state;
    logic           din_rdy;
    logic           row_vld;
    logic           wr_acc, rd_acc;
    logic           wr_last, rd_last;
    row_t           rd0, rd1;

    // The write bank being full is exactly the stall condition.
    assign wr_state = full[wb] ? WR_STALL : WR_FILL;
    assign din_rdy  = (wr_state == WR_FILL);
    assign row_vld  = full[rb];

    assign wr_acc   = io.din_vld & din_rdy;
    assign rd_acc   = row_vld & io.row_rdy;
    assign wr_last  = wr_acc & (wp == AW'(TILE_N - 1));
    assign rd_last  = rd_acc & (rr == RW'(T - 1));

    always_comb begin
        wp_nxt   = wp;
        rr_nxt   = rr;
        wb_nxt   = wb;
        rb_nxt   = rb;
        full_nxt = full;

        if (wr_acc) begin
            wp_nxt = wp + AW'(1);
        end
        if (wr_last) begin
            wp_nxt       = '0;
            wb_nxt       = ~wb;
            full_nxt[wb] = 1'b1;
        end

        if (rd_acc) begin
            rr_nxt = rr + RW'(1);
        end
        // wb==rb never sets and clears the same bank in one cycle, so both updates apply.
        if (rd_last) begin
            rr_nxt       = '0;
            rb_nxt       = ~rb;
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp   <= '0;
            rr   <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            full <= 2'b00;
        end else begin
            wp   <= wp_nxt;
            rr   <= rr_nxt;
            wb   <= wb_nxt;
            rb   <= rb_nxt;
            full <= full_nxt;
        end
    end

    wc_tile_bank u_bank0 (
        .clk   (clk),
        .we    (wr_acc & ~wb),
        .waddr (wp),
        .wdata (io.din),
        .ridx  (rr),
        .rdata (rd0)
    );

    wc_tile_bank u_bank1 (
        .clk   (clk),
        .we    (wr_acc & wb),
        .waddr (wp),
        .wdata (io.din),
        .ridx  (rr),
        .rdata (rd1)
    );

    assign io.din_rdy   = din_rdy;
    assign io.row_vld   = row_vld;
    assign io.row_idx   = rr;
    assign io.tile_last = row_vld & (rr == RW'(T - 1));
    // Bank contents are unreset, so hide them whenever no tile is presented.
    assign io.row_data  = row_vld ? (rb ? rd1 : rd0) : '0;

endmodule
